spi_slave_burst: RTL and testbench
==================================

Name: spi_slave_burst

Overview:
Parametrised SPI slave register-interface engine, successor to the single-transfer CPOL=0/CPHA=0 slave. Supports all four SPI modes, configurable address/data widths, and multi-word bursts with address auto-increment. Sits between the external SPI pins and the on-chip register file. Exposes a registered write strobe and a read request/data handshake, all in the `clk` domain.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, data word width in bits
CPOL, 0, SCLK idle level (0 = low, 1 = high)
CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
RD_LAT, 2, clk cycles from rd_req to valid rd_data (1..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock, asynchronous to clk
SSB  in  1  SPI select, active low, asynchronous
MOSI  in  1  master-out data, asynchronous
MISO  out  1  slave-out data
miso_oe  out  1  MISO output enable, for the pad tristate
wr_en  out  1  one-cycle write strobe
wr_addr  out  ADDR_W  write address, valid with wr_en
wr_data  out  DATA_W  write data, valid with wr_en
rd_req  out  1  one-cycle read request
rd_addr  out  ADDR_W  read address, valid with rd_req
rd_data  in  DATA_W  read data, sampled exactly RD_LAT cycles after rd_req
frame_err  out  1  one-cycle pulse: frame ended on a non-word boundary
busy  out  1  high while SSB is synchronised-low

Behaviour:
- Input synchronisation:
  - SCLK, SSB and MOSI each pass through a 2-flop synchroniser, plus one history flop for edge detection.
  - Reset values: SCLK chain = CPOL, SSB chain = 1, MOSI chain = 0.
- Edge decoding:
  - Leading edge = SCLK leaving CPOL; trailing edge = the opposite transition.
  - sample_edge = leading if CPHA=0, else trailing; shift_edge is the other.
  - Edges are ignored while SSB is high.
- Frame format, MSB-first:
  - 1 RW bit (1 = read, 0 = write), then ADDR_W address bits, then N >= 0 words of DATA_W bits.
  - Address auto-increments per word and wraps modulo 2^ADDR_W.
- States: IDLE, HDR, WR_DATA, RD_DATA.
  - IDLE -> HDR on SSB falling (synchronised); bit counter cleared.
  - HDR: shift MOSI into the header register on each sample_edge. After ADDR_W+1 bits, go to WR_DATA (RW=0) or RD_DATA (RW=1). A read issues rd_req with rd_addr = header address in the same cycle as the transition.
  - WR_DATA: shift on sample_edge. On the DATA_W-th bit, pulse wr_en on the next clk with wr_addr = current address and wr_data = the shifted word. Then increment the address and clear the bit counter.
  - RD_DATA: RD_LAT cycles after rd_req, load rd_data into the tx shift register.
    - CPHA=0: MSB is driven on the trailing edge that ends the last header bit. Subsequent bits are driven on each shift_edge.
    - CPHA=1: MSB is driven on the first leading edge of the word.
    - When the last bit of a word is sampled, increment the address and issue rd_req for the next word immediately (prefetch).
  - Any state -> IDLE on synchronised SSB rising. SSB rising has priority over a coincident SCLK edge.
- frame_err pulses one cycle on the SSB rise in these cases:
  - HDR has received at least 1 bit but fewer than ADDR_W+1 bits.
  - The data bit counter is not 0 (partial word).
  - A partial write word is discarded and never produces wr_en. A partial read needs no action.
- A frame with a header only (N=0) does not assert frame_err:
  - A read still issues exactly one rd_req.
  - A write issues no wr_en.
- MISO and miso_oe:
  - MISO = tx shift register MSB; miso_oe = 1 only in RD_DATA.
  - In IDLE, HDR and WR_DATA: MISO = 0, miso_oe = 0.
- Timing constraint on the environment: each SCLK half-period must be >= RD_LAT + 6 clk cycles. Behaviour under faster SCLK is undefined and not checked.
- Reset values: all outputs 0 except busy = 0 and MISO = 0. State = IDLE, counters and shift registers = 0.
- Reset asserted mid-frame returns to IDLE immediately with no strobes. The first frame after reset_n releases must start with a fresh SSB fall.
- Simultaneous events:
  - wr_en and a new sample_edge in the same cycle: both are handled, because the shift register and the write holding register are separate.
  - Back-to-back frames with SSB high for >= 3 clk are handled independently.

Test Plan:
- Mode 0, ADDR_W=7, DATA_W=8. Write frame 0|0x12, 0xA5, 0x3C -> wr_en twice: (0x12, 0xA5) then (0x13, 0x3C). No frame_err.
- Mode 3, read frame 1|0x40 with 2 words; register model returns addr^0xFF -> rd_req at 0x40 and 0x41 (plus a prefetch at 0x42). MISO bytes 0xBF then 0xBE. miso_oe high only during the data phase.
- Wrap: write 0|0x7F with 2 words 0x11, 0x22 -> wr_en (0x7F, 0x11) then (0x00, 0x22).
- Abort: write 0|0x05, 0xC3, then SSB rises after 5 data bits -> exactly one wr_en (0x05, 0xC3), then a frame_err pulse and no second write.
- Reset mid-frame: assert reset_n low during the 3rd data bit of a write -> no wr_en, all outputs 0. The next clean frame 0|0x01, 0x5A -> wr_en (0x01, 0x5A).
- Modes 1 and 2 with a single-word read at 0x00 returning 0x81 -> MISO bit sequence 1,0,0,0,0,0,0,1 sampled correctly on the master's sample edges.

Source files
------------

// File: rtl/spi_slave_burst_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_burst_if : SPI pin group plus register-file handshake bundle     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface spi_slave_burst_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              SCLK;
  logic              SSB;
  logic              MOSI;
  logic              MISO;
  logic              miso_oe;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  SCLK, SSB, MOSI, rd_data,
    output MISO, miso_oe, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
  );

  modport master (
    output SCLK, SSB, MOSI, rd_data,
    input  MISO, miso_oe, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_burst : SPI slave register engine, all modes, burst auto-incr    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_slave_burst #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0,
  parameter int RD_LAT = 2
) (
  input wire logic          clk,
  input wire logic          reset_n,
  spi_slave_burst_if.slave  spi_bus
);

  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam logic SAMPLE_TRAIL = (CPHA != 0);
  localparam int   MAX_BITS = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int   CNT_W = $clog2(MAX_BITS + 1);
  localparam int   LAT_W = 3;
  // Counter runs RD_LAT+1 .. 1 so the load edge is the one closing the valid cycle
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic              r_ssb_s1, r_ssb_s2, r_ssb_h;
  logic              r_mosi_s1, r_mosi_s2;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [ADDR_W-1:0] r_hdr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic [LAT_W-1:0]  r_lat;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_frame_err;

  logic              w_lead, w_trail, w_sample, w_shift;
  logic              w_ssb_fall, w_ssb_rise;
  logic [ADDR_W:0]   w_hdr_shift;
  logic [DATA_W-1:0] w_rx_shift;
  logic              w_hdr_done, w_word_done, w_frame_err;
  logic [ADDR_W-1:0] w_addr_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s1 <= SCLK_IDLE;
      r_sclk_s2 <= SCLK_IDLE;
      r_sclk_h  <= SCLK_IDLE;
      r_ssb_s1  <= 1'b1;
      r_ssb_s2  <= 1'b1;
      r_ssb_h   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_bus.SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_h  <= r_sclk_s2;
      r_ssb_s1  <= spi_bus.SSB;
      r_ssb_s2  <= r_ssb_s1;
      r_ssb_h   <= r_ssb_s2;
      r_mosi_s1 <= spi_bus.MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_lead      = ~r_ssb_s2 & (r_sclk_s2 != SCLK_IDLE) & (r_sclk_h == SCLK_IDLE);
  assign w_trail     = ~r_ssb_s2 & (r_sclk_s2 == SCLK_IDLE) & (r_sclk_h != SCLK_IDLE);
  assign w_sample    = SAMPLE_TRAIL ? w_trail : w_lead;
  assign w_shift     = SAMPLE_TRAIL ? w_lead : w_trail;
  assign w_ssb_fall  = ~r_ssb_s2 & r_ssb_h;
  assign w_ssb_rise  = r_ssb_s2 & ~r_ssb_h;
  assign w_hdr_shift = {r_hdr, r_mosi_s2};
  assign w_rx_shift  = {r_rx, r_mosi_s2};
  assign w_addr_inc  = r_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_done  = 1'b0;
    w_word_done = 1'b0;
    w_frame_err = 1'b0;
    if (w_ssb_rise) begin
      w_state_nxt = S_IDLE;
      w_frame_err = (r_state != S_IDLE) && (r_bitcnt != '0);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ssb_fall) begin
            w_state_nxt = S_HDR;
          end
        end
        S_HDR: begin
          if (w_sample && (r_bitcnt == CNT_W'(ADDR_W))) begin
            w_hdr_done  = 1'b1;
            w_state_nxt = w_hdr_shift[ADDR_W] ? S_RD : S_WR;
          end
        end
        S_WR, S_RD: begin
          w_word_done = w_sample && (r_bitcnt == CNT_W'(DATA_W - 1));
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt    <= '0;
      r_hdr       <= '0;
      r_addr      <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_lat       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_req    <= 1'b0;
      r_frame_err <= w_frame_err;
      if (r_lat != '0) begin
        r_lat <= r_lat - LAT_W'(1);
      end
      if (w_ssb_rise || (r_state == S_IDLE)) begin
        r_bitcnt <= '0;
        r_tx     <= '0;
        r_lat    <= '0;
      end else begin
        case (r_state)
          S_HDR: begin
            if (w_sample) begin
              r_hdr    <= w_hdr_shift[ADDR_W-1:0];
              r_bitcnt <= w_hdr_done ? '0 : r_bitcnt + CNT_W'(1);
              if (w_hdr_done) begin
                r_addr <= w_hdr_shift[ADDR_W-1:0];
                if (w_hdr_shift[ADDR_W]) begin
                  r_rd_req  <= 1'b1;
                  r_rd_addr <= w_hdr_shift[ADDR_W-1:0];
                  r_lat     <= LAT_INIT;
                end
              end
            end
          end
          S_WR: begin
            if (w_sample) begin
              r_rx <= w_rx_shift[DATA_W-2:0];
              if (w_word_done) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_rx_shift;
                r_addr    <= w_addr_inc;
                r_bitcnt  <= '0;
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          S_RD: begin
            // A word's first shift edge must leave the freshly loaded MSB in place
            if (r_lat == LAT_W'(1)) begin
              r_tx <= spi_bus.rd_data;
            end else if (w_shift && (r_bitcnt != '0)) begin
              r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_sample) begin
              if (w_word_done) begin
                r_addr    <= w_addr_inc;
                r_rd_req  <= 1'b1;
                r_rd_addr <= w_addr_inc;
                r_lat     <= LAT_INIT;
                r_bitcnt  <= '0;
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_bus.MISO      = (r_state == S_RD) & r_tx[DATA_W-1];
  assign spi_bus.miso_oe   = (r_state == S_RD);
  assign spi_bus.wr_en     = r_wr_en;
  assign spi_bus.wr_addr   = r_wr_addr;
  assign spi_bus.wr_data   = r_wr_data;
  assign spi_bus.rd_req    = r_rd_req;
  assign spi_bus.rd_addr   = r_rd_addr;
  assign spi_bus.frame_err = r_frame_err;
  assign spi_bus.busy      = ~r_ssb_s2;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_slave_burst : one DUT per SPI mode, directed plus random frames     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_slave_burst;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int RL   = 2;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk_v [4];
  logic       ssb_v  [4];
  logic       mosi_v [4];
  logic [7:0] rd_data_v [4];
  logic       miso_w [4];
  logic       oe_w   [4];
  logic       wr_en_w [4];
  logic       rd_req_w [4];
  logic       ferr_w [4];
  logic       busy_w [4];
  logic [6:0] wr_addr_w [4];
  logic [6:0] rd_addr_w [4];
  logic [7:0] wr_data_w [4];

  logic [7:0]  mem [128];
  logic [7:0]  wbuf [8];
  logic [16:0] wq[$];
  logic [8:0]  rq[$];
  int          fe_cnt [4];
  int          pend [4];
  logic [6:0]  paddr [4];
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_burst_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();
    assign u_if.SCLK    = sclk_v[g];
    assign u_if.SSB     = ssb_v[g];
    assign u_if.MOSI    = mosi_v[g];
    assign u_if.rd_data = rd_data_v[g];
    assign miso_w[g]    = u_if.MISO;
    assign oe_w[g]      = u_if.miso_oe;
    assign wr_en_w[g]   = u_if.wr_en;
    assign wr_addr_w[g] = u_if.wr_addr;
    assign wr_data_w[g] = u_if.wr_data;
    assign rd_req_w[g]  = u_if.rd_req;
    assign rd_addr_w[g] = u_if.rd_addr;
    assign ferr_w[g]    = u_if.frame_err;
    assign busy_w[g]    = u_if.busy;

    spi_slave_burst #(
      .ADDR_W(AW), .DATA_W(DW), .CPOL(g / 2), .CPHA(g % 2), .RD_LAT(RL)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .spi_bus (u_if.slave)
    );
  end

  // Register-file model: rd_data is only valid in the one cycle RD_LAT after rd_req
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic [1:0] mi;
      mi = 2'(i);
      if (wr_en_w[mi] === 1'b1) wq.push_back({mi, wr_addr_w[mi], wr_data_w[mi]});
      if (ferr_w[mi] === 1'b1) fe_cnt[mi]++;
      rd_data_v[mi] = 8'($urandom);
      if (pend[mi] > 0) begin
        pend[mi]--;
        if (pend[mi] == 0) rd_data_v[mi] = mem[paddr[mi]];
      end
      if (rd_req_w[mi] === 1'b1) begin
        rq.push_back({mi, rd_addr_w[mi]});
        pend[mi]  = RL;
        paddr[mi] = rd_addr_w[mi];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_h();
    repeat (HALF) @(negedge clk);
  endtask

  // One SPI bit from the master's point of view; MISO captured at the master's sample edge
  task automatic bit_xfer(input logic [1:0] m, input logic mo, output logic mi, output logic oe);
    logic cpol;
    cpol = m[1];
    if (!m[0]) begin
      mosi_v[m] = mo;
      wait_h();
      mi = miso_w[m];
      oe = oe_w[m];
      sclk_v[m] = ~cpol;
      wait_h();
      sclk_v[m] = cpol;
    end else begin
      sclk_v[m] = ~cpol;
      mosi_v[m] = mo;
      wait_h();
      mi = miso_w[m];
      oe = oe_w[m];
      sclk_v[m] = cpol;
      wait_h();
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input logic rw, input logic [6:0] a,
                           input int nw, input int xbits, input int nhdr);
    logic [7:0] sh;
    logic [7:0] rx;
    logic       mi, oe, hdr_oe_bad, dat_oe_bad, exp_err;
    int         wq0, rq0, fe0, nb, nwr, nrd;
    wq0 = wq.size();
    rq0 = rq.size();
    fe0 = fe_cnt[m];
    hdr_oe_bad = 1'b0;
    dat_oe_bad = 1'b0;
    rx = 8'h00;
    ssb_v[m] = 1'b0;
    wait_h();
    chk($sformatf("m%0d busy in frame", m), 32'(busy_w[m]), 32'(1));
    sh = {rw, a};
    for (int i = 0; i < nhdr; i++) begin
      bit_xfer(m, sh[7], mi, oe);
      sh = {sh[6:0], 1'b0};
      if (oe !== 1'b0) hdr_oe_bad = 1'b1;
    end
    if (nhdr == 8) begin
      for (int k = 0; k <= nw; k++) begin
        nb = (k < nw) ? 8 : xbits;
        sh = wbuf[3'(k)];
        for (int b = 0; b < nb; b++) begin
          bit_xfer(m, sh[7], mi, oe);
          sh = {sh[6:0], 1'b0};
          rx = {rx[6:0], mi};
          if (oe !== 1'b1) dat_oe_bad = 1'b1;
        end
        if (rw && nb == 8)
          chk($sformatf("m%0d miso word %0d", m, k), 32'(rx), 32'(mem[7'(32'(a) + k)]));
      end
    end
    wait_h();
    ssb_v[m] = 1'b1;
    repeat (8) @(negedge clk);
    chk($sformatf("m%0d busy after frame", m), 32'(busy_w[m]), 32'(0));
    nwr = (!rw && nhdr == 8) ? nw : 0;
    nrd = (rw && nhdr == 8) ? nw + 1 : 0;
    exp_err = (nhdr > 0 && nhdr < 8) || (nhdr == 8 && xbits != 0);
    chk($sformatf("m%0d wr count", m), 32'(wq.size() - wq0), 32'(nwr));
    for (int k = 0; k < nwr && (wq0 + k) < wq.size(); k++)
      chk($sformatf("m%0d wr entry %0d", m, k), 32'(wq[wq0 + k]),
          32'({m, 7'(32'(a) + k), wbuf[3'(k)]}));
    chk($sformatf("m%0d rd count", m), 32'(rq.size() - rq0), 32'(nrd));
    for (int k = 0; k < nrd && (rq0 + k) < rq.size(); k++)
      chk($sformatf("m%0d rd addr %0d", m, k), 32'(rq[rq0 + k]), 32'({m, 7'(32'(a) + k)}));
    chk($sformatf("m%0d frame_err pulses", m), 32'(fe_cnt[m] - fe0), 32'(exp_err));
    if (nhdr > 0) chk($sformatf("m%0d oe in header", m), 32'(hdr_oe_bad), 32'(0));
    if (rw && nhdr == 8 && (nw > 0 || xbits > 0))
      chk($sformatf("m%0d oe in data", m), 32'(dat_oe_bad), 32'(0));
  endtask

  initial begin
    logic mi, oe;
    logic sh_bit;
    logic [7:0] hb;
    int wq0, fe0, rnw, rx, rh;
    for (int i = 0; i < 4; i++) begin
      sclk_v[i] = (i >= 2);
      ssb_v[i]  = 1'b1;
      mosi_v[i] = 1'b0;
    end
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hFF;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset outputs m%0d", i),
          32'({miso_w[i], oe_w[i], wr_en_w[i], rd_req_w[i], ferr_w[i], busy_w[i], wr_addr_w[i], wr_data_w[i], rd_addr_w[i]}),
          32'(0));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    run_frame(2'd0, 1'b0, 7'h12, 2, 0, 8);
    run_frame(2'd3, 1'b1, 7'h40, 2, 0, 8);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    run_frame(2'd0, 1'b0, 7'h7F, 2, 0, 8);
    wbuf[0] = 8'hC3; wbuf[1] = 8'hFF;
    run_frame(2'd0, 1'b0, 7'h05, 1, 5, 8);
    mem[0] = 8'h81;
    run_frame(2'd1, 1'b1, 7'h00, 1, 0, 8);
    run_frame(2'd2, 1'b1, 7'h00, 1, 0, 8);
    run_frame(2'd2, 1'b1, 7'h33, 0, 0, 8);
    run_frame(2'd1, 1'b0, 7'h21, 0, 0, 8);
    run_frame(2'd3, 1'b0, 7'h21, 0, 0, 4);

    // Reset in the middle of the 3rd data bit of a mode-0 write
    wq0 = wq.size();
    fe0 = fe_cnt[0];
    ssb_v[0] = 1'b0;
    wait_h();
    hb = 8'h33;
    for (int i = 0; i < 10; i++) begin
      sh_bit = hb[7];
      hb = {hb[6:0], 1'b1};
      bit_xfer(2'd0, sh_bit, mi, oe);
    end
    mosi_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("outputs held in reset",
        32'({miso_w[0], oe_w[0], wr_en_w[0], rd_req_w[0], ferr_w[0], busy_w[0], wr_addr_w[0], wr_data_w[0], rd_addr_w[0]}),
        32'(0));
    sclk_v[0] = 1'b0;
    ssb_v[0]  = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no write from aborted frame", 32'(wq.size() - wq0), 32'(0));
    chk("no frame_err from reset", 32'(fe_cnt[0] - fe0), 32'(0));
    wbuf[0] = 8'h5A;
    run_frame(2'd0, 1'b0, 7'h01, 1, 0, 8);

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      rnw = $urandom_range(0, 3);
      rx  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      rh  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : 8;
      run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 7'($urandom),
                rnw, rx, rh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
